// File: rtl/scr1_memif_pkg.sv
// Shared encodings for the core-side memory request/response interfaces.
package scr1_memif_pkg;

    localparam int unsigned SCR1_MEM_WAIT_MAX = 15;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE = 2'b00,
        SCR1_MEM_WIDTH_HALF = 2'b01,
        SCR1_MEM_WIDTH_WORD = 2'b10,
        SCR1_MEM_WIDTH_RSVD = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_IDLE  = 2'b00,
        SCR1_MEM_RESP_OKAY  = 2'b01,
        SCR1_MEM_RESP_ERROR = 2'b10
    } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_mem_lane_align.sv
// Byte-lane steering between right-aligned core data and a 32-bit byte-enabled memory word.
module scr1_mem_lane_align
    import scr1_memif_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] qb_i,
    output logic [3:0]  web_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] qb_shifted;

    assign qb_shifted = qb_i >> {addr_i, 3'b000};

    always_comb begin
        web_o   = '0;
        wdata_o = '0;
        rdata_o = '0;
        case (type_scr1_mem_width_e'(width_i))
            SCR1_MEM_WIDTH_BYTE: begin
                web_o   = 4'b0001 << addr_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'd0, qb_shifted[7:0]};
            end
            SCR1_MEM_WIDTH_HALF: begin
                web_o   = 4'b0011 << addr_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'd0, qb_shifted[15:0]};
            end
            SCR1_MEM_WIDTH_WORD: begin
                web_o   = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = qb_shifted;
            end
            default: begin
                web_o   = '0;
                wdata_o = '0;
                rdata_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/scr1_dmem_mem_bridge.sv
// Data-memory bridge: one request at a time to TCM port B, with checks and wait states.
module scr1_dmem_mem_bridge
    import scr1_memif_pkg::*;
#(
    parameter int SCR1_WIDTH       = 32,
    parameter int SCR1_SIZE        = 'h10000,
    parameter int SCR1_WAIT_STATES = 0,
    localparam int AW              = $clog2(SCR1_SIZE)
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dmem_req,
    input  logic                  dmem_cmd,
    input  logic [1:0]            dmem_width,
    input  logic [31:0]           dmem_addr,
    input  logic [SCR1_WIDTH-1:0] dmem_wdata,
    output logic                  dmem_req_ack,
    output logic [SCR1_WIDTH-1:0] dmem_rdata,
    output logic [1:0]            dmem_resp,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [3:0]            mem_web,
    output logic [AW-1:0]         mem_addr,
    output logic [SCR1_WIDTH-1:0] mem_wdata,
    input  logic [SCR1_WIDTH-1:0] mem_qb
);

    localparam int unsigned CNT_W = $clog2(SCR1_MEM_WAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e                state_q;
    type_scr1_mem_cmd_e    cmd_q;
    type_scr1_mem_width_e  width_q;
    logic [AW-1:0]         addr_q;
    logic [SCR1_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  req_err;
    logic [3:0]            lane_web;
    logic [SCR1_WIDTH-1:0] lane_wdata;
    logic [SCR1_WIDTH-1:0] lane_rdata;

    // Out-of-range means any address bit at or above the memory size is set.
    assign req_err = (dmem_width == SCR1_MEM_WIDTH_RSVD)
                   | ((dmem_width == SCR1_MEM_WIDTH_HALF) & dmem_addr[0])
                   | ((dmem_width == SCR1_MEM_WIDTH_WORD) & (dmem_addr[1:0] != 2'b00))
                   | ((dmem_addr >> AW) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= SCR1_MEM_CMD_RD;
            width_q <= SCR1_MEM_WIDTH_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dmem_req) begin
                        cmd_q   <= type_scr1_mem_cmd_e'(dmem_cmd);
                        width_q <= type_scr1_mem_width_e'(dmem_width);
                        addr_q  <= dmem_addr[AW-1:0];
                        wdata_q <= dmem_wdata;
                        err_q   <= req_err;
                        if (req_err) begin
                            state_q <= ST_RESP;
                        end else if (SCR1_WAIT_STATES > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(SCR1_WAIT_STATES - 1);
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACCESS: state_q <= ST_RESP;
                ST_RESP:   state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    scr1_mem_lane_align u_lane_align (
        .width_i (width_q),
        .addr_i  (addr_q[1:0]),
        .wdata_i (wdata_q),
        .qb_i    (mem_qb),
        .web_o   (lane_web),
        .wdata_o (lane_wdata),
        .rdata_o (lane_rdata)
    );

    assign dmem_req_ack = (state_q == ST_IDLE);

    assign mem_ren   = (state_q == ST_ACCESS) & (cmd_q == SCR1_MEM_CMD_RD);
    assign mem_wen   = (state_q == ST_ACCESS) & (cmd_q == SCR1_MEM_CMD_WR);
    assign mem_web   = mem_wen ? lane_web : '0;
    assign mem_wdata = mem_wen ? lane_wdata : '0;
    assign mem_addr  = (state_q == ST_ACCESS) ? addr_q : '0;

    assign dmem_resp  = (state_q != ST_RESP) ? SCR1_MEM_RESP_IDLE :
                        (err_q ? SCR1_MEM_RESP_ERROR : SCR1_MEM_RESP_OKAY);
    assign dmem_rdata = ((state_q == ST_RESP) & !err_q & (cmd_q == SCR1_MEM_CMD_RD))
                        ? lane_rdata : '0;

endmodule

// File: tb/tb_scr1_dmem_mem_bridge.sv
// Bench: two bridges (0 and 3 wait states) on byte-lane memory models, checked against a byte-array reference.
module tb_scr1_dmem_mem_bridge;

    localparam int SIZE = 'h10000;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        req   [2];
    logic        cmd   [2];
    logic [1:0]  width [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic [1:0]  resp  [2];
    logic        ren   [2];
    logic        wen   [2];
    logic [3:0]  web   [2];
    logic [15:0] maddr [2];
    logic [31:0] mwdata[2];
    logic [31:0] qb    [2];

    logic [7:0]  refm [2][SIZE];

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] ram [16384];
        int          wr_cnt;

        scr1_dmem_mem_bridge #(
            .SCR1_WIDTH       (32),
            .SCR1_SIZE        (SIZE),
            .SCR1_WAIT_STATES ((g == 0) ? 0 : 3)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .dmem_req     (req[g]),
            .dmem_cmd     (cmd[g]),
            .dmem_width   (width[g]),
            .dmem_addr    (addr[g]),
            .dmem_wdata   (wdata[g]),
            .dmem_req_ack (ack[g]),
            .dmem_rdata   (rdata[g]),
            .dmem_resp    (resp[g]),
            .mem_ren      (ren[g]),
            .mem_wen      (wen[g]),
            .mem_web      (web[g]),
            .mem_addr     (maddr[g]),
            .mem_wdata    (mwdata[g]),
            .mem_qb       (qb[g])
        );

        always @(posedge clk) begin
            if (clr) begin
                wr_cnt = 0;
                for (int k = 0; k < 16384; k++) ram[k] <= '0;
            end else begin
                if (wen[g]) begin
                    wr_cnt = wr_cnt + 1;
                    for (int b = 0; b < 4; b++)
                        if (web[g][b]) ram[maddr[g][15:2]][8*b +: 8] <= mwdata[g][8*b +: 8];
                end
                if (ren[g]) qb[g] <= ram[maddr[g][15:2]];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_rst(input int i, input string tag);
        chk({tag, "_ack"},   32'(ack[i]), 32'd1);
        chk({tag, "_resp"},  32'(resp[i]), 32'd0);
        chk({tag, "_rdata"}, rdata[i], 32'd0);
        chk({tag, "_strb"},  {30'd0, ren[i], wen[i]}, 32'd0);
        chk({tag, "_web"},   32'(web[i]), 32'd0);
        chk({tag, "_maddr"}, 32'(maddr[i]), 32'd0);
        chk({tag, "_mwd"},   mwdata[i], 32'd0);
    endtask

    function automatic bit model_err(input logic [1:0] w, input logic [31:0] a);
        return (w == 2'd3) || (w == 2'd1 && a[0]) || (w == 2'd2 && a[1:0] != 2'd0) || (a >= SIZE);
    endfunction

    function automatic logic [31:0] model_read(input int i, input logic [1:0] w, input logic [31:0] a);
        logic [31:0] r = '0;
        for (int k = 0; k < (1 << w); k++) r = r | (32'(refm[i][a + k]) << (8 * k));
        return r;
    endfunction

    // Held requests keep req high with junk fields; otherwise drop req but still change fields.
    task automatic scramble(input int i, input bit hold);
        req[i]   = hold;
        cmd[i]   = 1'($urandom);
        width[i] = 2'($urandom);
        addr[i]  = $urandom;
        wdata[i] = $urandom;
    endtask

    task automatic txn(input int i, input logic c, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] d, input bit e_err, input logic [31:0] e_rd,
                       input bit hold, input string tag);
        int          ws = (i == 0) ? 0 : 3;
        logic [3:0]  e_web = '0;
        logic [31:0] e_wd;
        req[i] = 1'b1; cmd[i] = c; width[i] = w; addr[i] = a; wdata[i] = d;
        chk({tag, "_acc_ack"},  32'(ack[i]), 32'd1);
        chk({tag, "_acc_resp"}, 32'(resp[i]), 32'd0);
        @(negedge clk);
        scramble(i, hold);
        if (e_err) begin
            chk({tag, "_err_resp"},  32'(resp[i]), 32'd2);
            chk({tag, "_err_rdata"}, rdata[i], 32'd0);
            chk({tag, "_err_strb"},  {30'd0, ren[i], wen[i]}, 32'd0);
            chk({tag, "_err_ack"},   32'(ack[i]), 32'd0);
        end else begin
            repeat (ws) begin
                chk({tag, "_wait_ack"},  32'(ack[i]), 32'd0);
                chk({tag, "_wait_resp"}, 32'(resp[i]), 32'd0);
                chk({tag, "_wait_strb"}, {30'd0, ren[i], wen[i]}, 32'd0);
                @(negedge clk);
            end
            for (int k = 0; k < (1 << w); k++) e_web[int'(a[1:0]) + k] = 1'b1;
            case (w)
                2'd0:    e_wd = {4{d[7:0]}};
                2'd1:    e_wd = {2{d[15:0]}};
                default: e_wd = d;
            endcase
            chk({tag, "_strb"},  {30'd0, ren[i], wen[i]}, c ? 32'd1 : 32'd2);
            chk({tag, "_maddr"}, 32'(maddr[i]), {16'd0, a[15:0]});
            chk({tag, "_sack"},  32'(ack[i]), 32'd0);
            if (c) begin
                chk({tag, "_web"}, 32'(web[i]), 32'(e_web));
                chk({tag, "_mwd"}, mwdata[i], e_wd);
            end
            @(negedge clk);
            chk({tag, "_resp"},  32'(resp[i]), 32'd1);
            chk({tag, "_rdata"}, rdata[i], c ? 32'd0 : e_rd);
            chk({tag, "_rstrb"}, {30'd0, ren[i], wen[i]}, 32'd0);
            if (c) for (int k = 0; k < (1 << w); k++) refm[i][a + k] = d[8*k +: 8];
        end
        @(negedge clk);
        chk({tag, "_idle_resp"}, 32'(resp[i]), 32'd0);
        chk({tag, "_idle_ack"},  32'(ack[i]), 32'd1);
    endtask

    typedef struct {
        logic        c;
        logic [1:0]  w;
        logic [31:0] a;
        logic [31:0] d;
        bit          err;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rw;
        logic [31:0] ra;
        logic        rc;
        int          wc_before;

        tbl[0]  = '{1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 2'd2, 32'h0000_0200, 32'h1122_3344, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 2'd0, 32'h0000_0203, 32'h0000_00A5, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 2'd2, 32'h0000_0200, 32'h0,         1'b0, 32'hA522_3344};
        tbl[5]  = '{1'b0, 2'd0, 32'h0000_0203, 32'h0,         1'b0, 32'h0000_00A5};
        tbl[6]  = '{1'b0, 2'd1, 32'h0000_0202, 32'h0,         1'b0, 32'h0000_A522};
        tbl[7]  = '{1'b0, 2'd1, 32'h0000_0201, 32'h0,         1'b1, 32'h0};
        tbl[8]  = '{1'b1, 2'd2, 32'h0001_0000, 32'h5555_AAAA, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 2'd3, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
        tbl[10] = '{1'b0, 2'd2, 32'h0000_0102, 32'h0,         1'b1, 32'h0};
        tbl[11] = '{1'b0, 2'd0, 32'h0000_0101, 32'h0,         1'b0, 32'h0000_00BE};
        tbl[12] = '{1'b1, 2'd1, 32'h0000_0102, 32'h0000_CAFE, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 2'd2, 32'h0000_0100, 32'h0,         1'b0, 32'hCAFE_BEEF};
        tbl[14] = '{1'b0, 2'd2, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};

        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; cmd[i] = 1'b0; width[i] = 2'd0; addr[i] = '0; wdata[i] = '0;
            for (int k = 0; k < SIZE; k++) refm[i][k] = 8'h00;
        end
        rst_n = 1'b0;
        clr   = 1'b1;
        repeat (3) @(negedge clk);
        chk_rst(0, "rst0");
        chk_rst(1, "rst1");
        clr   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 15; k++)
            txn(0, tbl[k].c, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].err, tbl[k].rd, 1'b0, $sformatf("vec%0d", k));

        // Three wait states, request held high across back-to-back transactions.
        txn(1, 1'b1, 2'd2, 32'h40, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b1, "w3_wr");
        txn(1, 1'b0, 2'd2, 32'h40, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b1, "w3_rd");
        txn(1, 1'b0, 2'd0, 32'h41, 32'h0,         1'b0, 32'h0000_00F0, 1'b1, "w3_rdb");
        txn(1, 1'b1, 2'd1, 32'h46, 32'h0000_1234, 1'b0, 32'h0,         1'b1, "w3_wrh");
        txn(1, 1'b0, 2'd2, 32'h44, 32'h0,         1'b0, 32'h1234_0000, 1'b1, "w3_rd2");
        txn(1, 1'b0, 2'd1, 32'h201, 32'h0,        1'b1, 32'h0,         1'b0, "w3_err");

        // Reset during WAIT.
        wc_before = g_dut[1].wr_cnt;
        req[1] = 1'b1; cmd[1] = 1'b1; width[1] = 2'd2; addr[1] = 32'h80; wdata[1] = 32'h1234_5678;
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_rst(1, "rstwait");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during ACCESS, before the write edge.
        req[1] = 1'b1; cmd[1] = 1'b1; width[1] = 2'd2; addr[1] = 32'h80; wdata[1] = 32'h1234_5678;
        @(negedge clk);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstacc_in_access", 32'(wen[1]), 32'd1);
        rst_n = 1'b0;
        #1 chk_rst(1, "rstacc");
        @(posedge clk);
        #1;
        chk("rstacc_ram", g_dut[1].ram[32], 32'h0);
        chk("rstacc_wrcnt", 32'(g_dut[1].wr_cnt), 32'(wc_before));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1, 1'b0, 2'd2, 32'h80, 32'h0,         1'b0, 32'h0,         1'b0, "post_rd0");
        txn(1, 1'b1, 2'd2, 32'h80, 32'h1234_5678, 1'b0, 32'h0,         1'b0, "post_wr");
        txn(1, 1'b0, 2'd2, 32'h80, 32'h0,         1'b0, 32'h1234_5678, 1'b0, "post_rd");

        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 40; r++) begin
                rc = 1'($urandom);
                rw = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                ra = 32'h300 + 32'($urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) ra = ra | (32'h1_0000 << $urandom_range(0, 15));
                txn(i, rc, rw, ra, $urandom, model_err(rw, ra),
                    model_err(rw, ra) ? 32'h0 : model_read(i, rw, ra),
                    1'($urandom_range(0, 1)), $sformatf("rnd%0d_%0d", i, r));
            end
            req[i] = 1'b0;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scr1_dmem_mem_bridge.md
# scr1_dmem_mem_bridge

Bridge from the core data-memory request/response interface to port B of the dual-port byte-enabled TCM. Accepts one request at a time. Checks width, alignment and range, and inserts a configurable number of wait states. Generates byte enables and lane-shifted write data, then returns right-aligned read data with an OKAY/ERROR response.

## Interface
Parameters:
- SCR1_WIDTH, 32, data width; only 32 is supported.
- SCR1_SIZE, 'h10000, memory size in bytes, power of two; AW = $clog2(SCR1_SIZE).
- SCR1_WAIT_STATES, 0, extra cycles (0..15) between accept and memory strobe.

Ports:
- clk  in  1  clock; the only clock domain.
- rst_n  in  1  asynchronous active-low reset.
- dmem_req  in  1  request valid.
- dmem_cmd  in  1  0 = read, 1 = write.
- dmem_width  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- dmem_addr  in  32  byte address.
- dmem_wdata  in  32  write data, right-aligned.
- dmem_req_ack  out  1  request accepted this cycle.
- dmem_rdata  out  32  read data, right-aligned, zero-extended.
- dmem_resp  out  2  00 = IDLE, 01 = OKAY, 10 = ERROR.
- mem_ren  out  1  memory port B read enable.
- mem_wen  out  1  memory port B write enable.
- mem_web  out  4  byte-lane write enables.
- mem_addr  out  AW  byte address to the memory.
- mem_wdata  out  32  lane-positioned write data.
- mem_qb  in  32  memory read data; valid one cycle after mem_ren.

## Operation
- Reset state: IDLE. All capture registers and the wait counter clear to 0.
- Output reset values: dmem_req_ack=1, dmem_resp=IDLE, dmem_rdata=0, mem_ren=0, mem_wen=0, mem_web=0, mem_addr=0, mem_wdata=0.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - dmem_req_ack=1 combinationally. A request is accepted when dmem_req=1.
  - On accept, capture cmd, width, addr[AW-1:0] and wdata, and evaluate the error flag.
- Error conditions:
  - width=11.
  - half access with addr[0]=1.
  - word access with addr[1:0]!=0.
  - addr[31:AW]!=0.
- IDLE transitions on accept:
  - Error: go to RESP with the error flag set. No memory strobe is issued.
  - No error, SCR1_WAIT_STATES>0: go to WAIT and load the counter with SCR1_WAIT_STATES-1.
  - No error, SCR1_WAIT_STATES=0: go to ACCESS.
- WAIT: decrement the counter each cycle. Go to ACCESS when the counter is 0.
- ACCESS:
  - Drive mem_addr from the captured address.
  - Read: mem_ren=1.
  - Write: mem_wen=1 with mem_web and mem_wdata set. mem_wdata = wdata replicated per width (byte ×4, half ×2).
  - mem_web: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111.
  - Always go to RESP.
- RESP:
  - dmem_resp = ERROR if the error flag is set, otherwise OKAY. Go to IDLE.
  - Read OKAY: dmem_rdata = (mem_qb >> 8*addr[1:0]) masked to width (byte 0xFF, half 0xFFFF).
  - Write, or any ERROR: dmem_rdata=0.
- Outside RESP: dmem_resp=IDLE and dmem_rdata=0.
- dmem_req_ack=0 in WAIT, ACCESS and RESP. dmem_req is ignored in those states.
- Request inputs are sampled only in the accept cycle; changes afterwards have no effect.
- Reset asserted in any state:
  - Immediately returns to IDLE and forces all outputs to their reset values.
  - An in-flight write in ACCESS is dropped if rst_n falls before the clock edge.

## Timing
- Accept at cycle T. Memory strobe at T+1+SCR1_WAIT_STATES. Response at T+2+SCR1_WAIT_STATES.
- Error response at T+1.
- Next accept no earlier than the cycle after RESP: IDLE is re-entered at T+3+SCR1_WAIT_STATES.
- mem_* outputs are combinational decodes of the state and capture registers; they carry no path from dmem_* inputs.
- dmem_rdata is combinational from mem_qb during RESP only.

## Structure
- Shared package scr1_memif_pkg:
  - Enums for cmd, width and resp encodings.
  - Constant SCR1_MEM_WAIT_MAX = 15.
- FSM state enum is local to the module.
- Sub-module scr1_mem_lane_align, purely combinational:
  - Inputs: width, addr[1:0], wdata, qb.
  - Outputs: web, positioned write data, aligned and masked read data.
  - It is the natural split and is reused by the instruction-side bridge.

## Test plan
- Word write then read, W=0:
  - Write 0xDEADBEEF to 0x100: mem_wen=1 with web=1111 at T+1; OKAY at T+2.
  - Read 0x100: rdata=0xDEADBEEF, OKAY at T+2.
- Byte write 0xA5 to 0x103 over 0x11223344:
  - mem_web=1000, mem_wdata=0xA5A5A5A5.
  - Word read returns 0xA5223344. Byte read of 0x103 returns 0x000000A5.
- Errors:
  - Half read at 0x201 → ERROR at T+1, no mem_ren/mem_wen pulse, rdata=0.
  - Word at 0x10000 with SIZE=0x10000 → ERROR.
  - width=11 → ERROR.
- W=3: accept at T → strobe at T+4, response at T+5. dmem_req_ack=0 from T+1 to T+5; a held dmem_req is accepted at T+6.
- Back-to-back dmem_req held high with changing addr: only the accept-cycle values are used, each response occurs exactly once, and dmem_resp=IDLE between responses.
- Reset mid-operation: rst_n low during WAIT or ACCESS → outputs return to reset values immediately, no memory write occurs, and the first request after release completes normally.
